hub75_bcm_scanner: RTL and testbench
====================================

// Module: hub75_bcm_scanner
// PURPOSE
//  Parametrised HUB75 panel scan engine; successor to the fixed 32x16, 1-bit test driver.
//  Reads RGB pixels from an external framebuffer port and shifts them into the panel, two scan halves per row.
//  Multiplexes rows with binary-coded modulation (BCM) for BPC bits per colour.
//  Sits between the framebuffer RAM and the Pmod pins (JB data / JC control).
// PARAMETERS
//  COLS     32  pixels per row; shift clocks per plane
//  ROWS     16  panel rows; scan rows = ROWS/2, ROWS even, >=4
//  BPC      4   bits per colour channel (bit planes), 1..8
//  CLK_DIV  4   clk cycles per hub_clk half-period, >=2
//  BASE_ON  64  clk cycles of display for plane 0; plane p gets BASE_ON<<p
//  ADDR_W   $clog2(ROWS/2)  hub_addr width, derived
// PORTS
//  clk          in   1        system clock, all logic on posedge
//  rst_n        in   1        asynchronous active-low reset
//  enable       in   1        run scanning; sampled at row boundary only
//  fb_row       out  ADDR_W   framebuffer scan-row address (top half; bottom = +ROWS/2 in RAM)
//  fb_col       out  $clog2(COLS)  framebuffer column address
//  fb_rd        out  1        read strobe; data valid exactly 1 clk later
//  fb_rdata     in   6*BPC    {r0,g0,b0,r1,g1,b1}, each BPC bits, MSB first
//  hub_rgb      out  6        {R0,G0,B0,R1,G1,B1}, selected plane bit
//  hub_addr     out  ADDR_W   panel row address A..; zero-extend to connector
//  hub_clk      out  1        shift clock, data captured by panel on rising edge
//  hub_lat      out  1        latch, active high
//  hub_blank    out  1        1 = LEDs off (drives OE_n)
//  frame_start  out  1        1-clk pulse when row 0 plane 0 shift begins
// BEHAVIOUR
//  Reset: hub_rgb=0, hub_clk=0, hub_lat=0, hub_blank=1, hub_addr=ROWS/2-1, fb_rd=0,
//   frame_start=0, state=IDLE, row=0, plane=0, col=0.
//  FSM: IDLE -> SHIFT -> BLANK -> LATCH -> SHOW -> (SHIFT next plane | IDLE/SHIFT next row).
//  IDLE: hub_blank=1; enable=1 -> SHIFT with row=0, plane=0, frame_start pulse.
//  SHIFT: per column: fb_rd=1 with fb_row=row, fb_col=col; next clk register bit [plane] of each
//   channel into hub_rgb with hub_clk=0; hold CLK_DIV clks; hub_clk=1 for CLK_DIV clks.
//   hub_rgb stable for whole hub_clk high phase. Exactly COLS rising edges per plane; hub_clk ends 0.
//  BLANK: hub_blank=1 for CLK_DIV clks; hub_addr <= row on the first cycle (ghost-free change).
//  LATCH: hub_lat=1 for CLK_DIV clks, then 0; hub_blank stays 1.
//  SHOW: hub_blank=0 for exactly BASE_ON<<plane clks; counter width >= BPC-1+$clog2(BASE_ON)+1.
//  After SHOW: plane<BPC-1 -> plane+1, SHIFT. Plane wrap -> row+1 (wrap ROWS/2-1 -> 0, frame_start
//   on row 0). At row boundary enable=0 -> IDLE with hub_blank=1; current row always completes.
//  Panel shows plane p-1 while nothing shifts; no overlap of shift and display (simple, deterministic).
//  Data for plane p shifted while previous plane blanked: colours exactly proportional to value.
//  fb_rd never asserted outside SHIFT; one read per column per plane (COLS*BPC reads per row).
//  rst_n low mid-operation: immediate async return to reset values, hub_blank=1 same instant.
//  BPC=1: single plane, SHOW = BASE_ON; behaviour otherwise identical.
// STRUCTURE
//  hub75_pkg: state encoding (IDLE,SHIFT,BLANK,LATCH,SHOW), channel index constants for fb_rdata
//   slicing, CH_W=6.
//  Sub-module hub75_tick_div: CLK_DIV phase counter with clear, emits half-period tick; used by
//   SHIFT, BLANK and LATCH. Top holds FSM, row/plane/col counters, SHOW timer.
// TESTING  (bench: COLS=4, ROWS=4, BPC=2, CLK_DIV=2, BASE_ON=8; RAM model, 1-clk latency)
//  Reset -> hub_blank=1, hub_lat=0, hub_clk=0, hub_addr=1 while enable=0; no fb_rd ever.
//  enable=1, all pixels 2'b11 -> per row 8 hub_clk rising edges (4/plane), hub_rgb=6'h3F at each.
//  Pixel r0=2'b10 elsewhere 0 -> plane0 R0=0, plane1 R0=1; SHOW lengths measured 8 then 16 clks.
//  Row sequence: hub_addr 0,1,0,... changes only while hub_blank=1; frame_start every 2 rows.
//  enable dropped mid-row 1 -> row 1 completes both planes, then IDLE, hub_blank=1, no more edges.
//  rst_n pulsed low during SHOW -> hub_blank=1 asynchronously; restart emits frame_start at row 0.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared encodings for the HUB75 BCM scanner: FSM states, shift sub-phases
// and the channel order used both on the panel pins and in framebuffer words.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_SHOW
  } state_t;

  // One column inside SHIFT: read strobe, data capture, hub_clk low, hub_clk high.
  typedef enum logic [1:0] {
    SP_RD,
    SP_CAP,
    SP_LO,
    SP_HI
  } shift_ph_t;

  localparam int CH_W = 6;

  // Bit position in hub_rgb and BPC-wide slot index in fb_rdata ({r0,g0,b0,r1,g1,b1}).
  localparam int CH_R0 = 5;
  localparam int CH_G0 = 4;
  localparam int CH_B0 = 3;
  localparam int CH_R1 = 2;
  localparam int CH_G1 = 1;
  localparam int CH_B1 = 0;

endpackage

// File: rtl/hub75_tick_div.sv
// Half-period phase counter: tick is high on the last of every DIV enabled
// cycles; clear returns the phase to zero.
module hub75_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hub75_bcm_scanner.sv
// HUB75 scan engine: shifts one bit plane per pass from the framebuffer into the
// panel, then latches and displays it for BASE_ON<<plane clocks (binary-coded modulation).
module hub75_bcm_scanner
  import hub75_pkg::*;
#(
  parameter int COLS    = 32,
  parameter int ROWS    = 16,
  parameter int BPC     = 4,
  parameter int CLK_DIV = 4,
  parameter int BASE_ON = 64,
  localparam int ADDR_W = $clog2(ROWS / 2)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  output logic [ADDR_W-1:0]       fb_row,
  output logic [$clog2(COLS)-1:0] fb_col,
  output logic                    fb_rd,
  input  logic [6*BPC-1:0]        fb_rdata,
  output logic [CH_W-1:0]         hub_rgb,
  output logic [ADDR_W-1:0]       hub_addr,
  output logic                    hub_clk,
  output logic                    hub_lat,
  output logic                    hub_blank,
  output logic                    frame_start
);

  localparam int COL_W   = $clog2(COLS);
  localparam int PLANE_W = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int SHOW_W  = BPC + $clog2(BASE_ON);

  state_t              state;
  shift_ph_t           sp;
  logic [PLANE_W-1:0]  plane;
  logic [SHOW_W-1:0]   show_cnt;
  logic [ADDR_W-1:0]   next_row;
  logic                div_en;
  logic                tick;
  logic [BPC-1:0]      ch_word [CH_W];
  logic [CH_W-1:0]     plane_bits;

  // Framebuffer port is fixed-latency: a 1-cycle fb_rd pulse returns fb_rdata on the
  // following cycle, with no stall or acknowledge in either direction.
  always_comb begin
    ch_word[CH_R0] = fb_rdata[CH_R0*BPC +: BPC];
    ch_word[CH_G0] = fb_rdata[CH_G0*BPC +: BPC];
    ch_word[CH_B0] = fb_rdata[CH_B0*BPC +: BPC];
    ch_word[CH_R1] = fb_rdata[CH_R1*BPC +: BPC];
    ch_word[CH_G1] = fb_rdata[CH_G1*BPC +: BPC];
    ch_word[CH_B1] = fb_rdata[CH_B1*BPC +: BPC];
    plane_bits        = '0;
    plane_bits[CH_R0] = ch_word[CH_R0][plane];
    plane_bits[CH_G0] = ch_word[CH_G0][plane];
    plane_bits[CH_B0] = ch_word[CH_B0][plane];
    plane_bits[CH_R1] = ch_word[CH_R1][plane];
    plane_bits[CH_G1] = ch_word[CH_G1][plane];
    plane_bits[CH_B1] = ch_word[CH_B1][plane];
  end

  assign next_row = (fb_row == ADDR_W'(ROWS / 2 - 1)) ? '0 : fb_row + 1'b1;

  assign div_en = ((state == ST_SHIFT) && ((sp == SP_LO) || (sp == SP_HI))) ||
                  (state == ST_BLANK) || (state == ST_LATCH);

  hub75_tick_div #(
    .DIV(CLK_DIV)
  ) u_tick_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(!div_en),
    .en   (div_en),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sp          <= SP_RD;
      plane       <= '0;
      fb_row      <= '0;
      fb_col      <= '0;
      show_cnt    <= '0;
      fb_rd       <= 1'b0;
      hub_rgb     <= '0;
      hub_addr    <= ADDR_W'(ROWS / 2 - 1);
      hub_clk     <= 1'b0;
      hub_lat     <= 1'b0;
      hub_blank   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      fb_rd       <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          hub_blank <= 1'b1;
          if (enable) begin
            fb_row      <= '0;
            plane       <= '0;
            fb_col      <= '0;
            sp          <= SP_RD;
            fb_rd       <= 1'b1;
            frame_start <= 1'b1;
            state       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          case (sp)
            SP_RD:  sp <= SP_CAP;
            SP_CAP: begin
              hub_rgb <= plane_bits;
              sp      <= SP_LO;
            end
            SP_LO: begin
              if (tick) begin
                hub_clk <= 1'b1;
                sp      <= SP_HI;
              end
            end
            SP_HI: begin
              if (tick) begin
                hub_clk <= 1'b0;
                if (fb_col == COL_W'(COLS - 1)) begin
                  // Address moves while the panel is dark so no ghost of the old row appears.
                  hub_addr <= fb_row;
                  state    <= ST_BLANK;
                end else begin
                  fb_col <= fb_col + 1'b1;
                  fb_rd  <= 1'b1;
                  sp     <= SP_RD;
                end
              end
            end
          endcase
        end
        ST_BLANK: begin
          if (tick) begin
            hub_lat <= 1'b1;
            state   <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          if (tick) begin
            hub_lat   <= 1'b0;
            hub_blank <= 1'b0;
            show_cnt  <= (SHOW_W'(BASE_ON) << plane) - 1'b1;
            state     <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (show_cnt == '0) begin
            hub_blank <= 1'b1;
            if (plane != PLANE_W'(BPC - 1)) begin
              plane  <= plane + 1'b1;
              fb_col <= '0;
              sp     <= SP_RD;
              fb_rd  <= 1'b1;
              state  <= ST_SHIFT;
            end else begin
              // Row boundary: the only point where enable is honoured.
              plane  <= '0;
              fb_row <= next_row;
              if (enable) begin
                fb_col      <= '0;
                sp          <= SP_RD;
                fb_rd       <= 1'b1;
                frame_start <= (next_row == '0);
                state       <= ST_SHIFT;
              end else begin
                state <= ST_IDLE;
              end
            end
          end else begin
            show_cnt <= show_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Bench for hub75_bcm_scanner: framebuffer RAM model, reference scan model feeding
// expected queues, and a negedge monitor that consumes them as the panel pins move.
module tb_hub75_bcm_scanner;

  localparam int COLS    = 4;
  localparam int ROWS    = 4;
  localparam int BPC     = 2;
  localparam int CLK_DIV = 2;
  localparam int BASE_ON = 8;
  localparam int SROWS   = ROWS / 2;
  localparam int ADDR_W  = $clog2(SROWS);
  localparam int COL_W   = $clog2(COLS);
  localparam int EPR     = COLS * BPC;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [ADDR_W-1:0] fb_row;
  logic [COL_W-1:0]  fb_col;
  logic              fb_rd;
  logic [6*BPC-1:0]  fb_rdata = '0;
  logic [5:0]        hub_rgb;
  logic [ADDR_W-1:0] hub_addr;
  logic              hub_clk, hub_lat, hub_blank, frame_start;

  hub75_bcm_scanner #(
    .COLS(COLS), .ROWS(ROWS), .BPC(BPC), .CLK_DIV(CLK_DIV), .BASE_ON(BASE_ON)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fb_row(fb_row), .fb_col(fb_col), .fb_rd(fb_rd), .fb_rdata(fb_rdata),
    .hub_rgb(hub_rgb), .hub_addr(hub_addr), .hub_clk(hub_clk), .hub_lat(hub_lat),
    .hub_blank(hub_blank), .frame_start(frame_start)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- framebuffer model ----------------
  logic [BPC-1:0] mem_r [ROWS][COLS];
  logic [BPC-1:0] mem_g [ROWS][COLS];
  logic [BPC-1:0] mem_b [ROWS][COLS];

  always @(posedge clk) begin
    if (fb_rd) begin
      fb_rdata <= {mem_r[int'(fb_row)][int'(fb_col)], mem_g[int'(fb_row)][int'(fb_col)],
                   mem_b[int'(fb_row)][int'(fb_col)],
                   mem_r[int'(fb_row) + SROWS][int'(fb_col)],
                   mem_g[int'(fb_row) + SROWS][int'(fb_col)],
                   mem_b[int'(fb_row) + SROWS][int'(fb_col)]};
    end
  end

  // ---------------- scoreboard ----------------
  logic [5:0] exp_q[$];
  int         show_q[$];
  int         addr_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: scan row k%SROWS; each plane shifts every column's bit p of the six
  // colour channels, then shows for BASE_ON*2^p clocks.
  function automatic logic [5:0] expect_rgb(input int r, input int c, input int p);
    logic [BPC-1:0] v [6];
    logic [5:0] o;
    v[0] = mem_r[r][c];         v[1] = mem_g[r][c];         v[2] = mem_b[r][c];
    v[3] = mem_r[r + SROWS][c]; v[4] = mem_g[r + SROWS][c]; v[5] = mem_b[r + SROWS][c];
    for (int i = 0; i < 6; i++) o[5 - i] = v[i][p];
    return o;
  endfunction

  task automatic push_rows(input int n);
    for (int k = 0; k < n; k++) begin
      for (int p = 0; p < BPC; p++) begin
        for (int c = 0; c < COLS; c++) exp_q.push_back(expect_rgb(k % SROWS, c, p));
        show_q.push_back(BASE_ON * (1 << p));
        addr_q.push_back(k % SROWS);
      end
    end
  endtask

  // ---------------- monitor ----------------
  int         edge_cnt = 0;
  int         rd_cnt = 0;
  int         fs_cnt = 0;
  int         test_base = 0;
  int         lit_run = 0;
  logic       prev_clk = 1'b0, prev_lat = 1'b0, prev_blank = 1'b1;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [5:0] hold_rgb = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_clk = 1'b0; prev_lat = 1'b0; prev_blank = 1'b1; lit_run = 0;
      prev_addr = hub_addr;
    end else begin
      if (fb_rd) begin
        rd_cnt++;
        chk("rd_only_while_blank", int'(hub_blank), 1);
      end
      if (hub_clk && !prev_clk) begin
        edge_cnt++;
        hold_rgb = hub_rgb;
        chk("rgb_edge_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("rgb_at_edge", int'(hub_rgb), int'(exp_q.pop_front()));
      end else if (hub_clk && hub_rgb != hold_rgb) begin
        chk("rgb_stable_high", int'(hub_rgb), int'(hold_rgb));
      end
      if (hub_lat && !prev_lat) begin
        chk("lat_while_blank", int'(hub_blank), 1);
        chk("lat_expected", int'(addr_q.size() > 0), 1);
        if (addr_q.size() > 0) chk("addr_at_latch", int'(hub_addr), addr_q.pop_front());
      end
      if (hub_addr != prev_addr) chk("addr_change_blanked", int'(hub_blank), 1);
      if (!hub_blank) begin
        lit_run++;
      end else if (!prev_blank) begin
        chk("show_expected", int'(show_q.size() > 0), 1);
        if (show_q.size() > 0) chk("show_length", lit_run, show_q.pop_front());
        lit_run = 0;
      end
      if (frame_start) begin
        fs_cnt++;
        chk("frame_start_row0", (edge_cnt - test_base) % (SROWS * EPR), 0);
      end
      prev_clk = hub_clk; prev_lat = hub_lat; prev_blank = hub_blank; prev_addr = hub_addr;
    end
  end

  // ---------------- driver ----------------
  task automatic fill(input int mode);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        case (mode)
          0: begin mem_r[r][c] = '1; mem_g[r][c] = '1; mem_b[r][c] = '1; end
          1: begin mem_r[r][c] = '0; mem_g[r][c] = '0; mem_b[r][c] = '0; end
          default: begin
            mem_r[r][c] = BPC'($urandom_range(0, (1 << BPC) - 1));
            mem_g[r][c] = BPC'($urandom_range(0, (1 << BPC) - 1));
            mem_b[r][c] = BPC'($urandom_range(0, (1 << BPC) - 1));
          end
        endcase
      end
    end
    if (mode == 1) mem_r[0][0] = 2'b10;
  endtask

  // Run n scan rows from row 0, dropping enable once the last row has started.
  task automatic run_test(input string tag, input int n);
    int base, rd_base, fs_base, t;
    base = edge_cnt; rd_base = rd_cnt; fs_base = fs_cnt;
    test_base = edge_cnt;
    push_rows(n);
    @(negedge clk);
    enable = 1'b1;
    t = 0;
    while (edge_cnt < base + (n - 1) * EPR + 1 && t < 5000) begin @(negedge clk); t++; end
    chk({tag, "_last_row_reached"}, int'(edge_cnt >= base + (n - 1) * EPR + 1), 1);
    enable = 1'b0;
    t = 0;
    while ((exp_q.size() + show_q.size() + addr_q.size()) != 0 && t < 5000) begin
      @(negedge clk); t++;
    end
    chk({tag, "_queues_drained"}, exp_q.size() + show_q.size() + addr_q.size(), 0);
    repeat (60) @(negedge clk);
    chk({tag, "_edges"}, edge_cnt - base, n * EPR);
    chk({tag, "_reads"}, rd_cnt - rd_base, n * EPR);
    chk({tag, "_frame_starts"}, fs_cnt - fs_base, (n + 1) / 2);
    chk({tag, "_idle_blank"}, int'(hub_blank), 1);
    chk({tag, "_idle_clk"}, int'(hub_clk), 0);
  endtask

  initial begin
    int t;
    fill(1);
    repeat (3) @(negedge clk);
    chk("rst_blank_in_reset", int'(hub_blank), 1);
    chk("rst_addr_in_reset", int'(hub_addr), SROWS - 1);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_blank", int'(hub_blank), 1);
    chk("idle_lat", int'(hub_lat), 0);
    chk("idle_clk", int'(hub_clk), 0);
    chk("idle_addr", int'(hub_addr), SROWS - 1);
    chk("idle_rgb", int'(hub_rgb), 0);
    chk("idle_frame_start", int'(frame_start), 0);
    chk("idle_no_reads", rd_cnt, 0);

    fill(0); run_test("all_ones", 2);
    fill(1); run_test("single_r0", 2);
    fill(2); run_test("random5", 5);

    // Async reset while the panel is lit, then restart from row 0.
    fill(2);
    push_rows(4);
    test_base = edge_cnt;
    @(negedge clk);
    enable = 1'b1;
    t = 0;
    while (hub_blank && t < 5000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk("lit_before_reset", int'(hub_blank), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_blank", int'(hub_blank), 1);
    chk("async_clk", int'(hub_clk), 0);
    chk("async_lat", int'(hub_lat), 0);
    chk("async_rd", int'(fb_rd), 0);
    chk("async_addr", int'(hub_addr), SROWS - 1);
    chk("async_rgb", int'(hub_rgb), 0);
    enable = 1'b0;
    exp_q.delete(); show_q.delete(); addr_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    fill(2); run_test("restart", 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
